// File: rtl/wb_cmd_initiator.sv
// Wishbone classic-cycle initiator: runs one bus cycle per valid/ready command
// and returns read data plus a timeout flag on a valid/ready response port.
module wb_cmd_initiator #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  output logic            busy_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // TIMEOUT=0 still needs a 1-bit timer so the vector is never zero-width.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] T_MAX  = '1;

  logic [1:0]    state;
  logic [TW-1:0] timer;

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign wbm_stb_o   = wbm_cyc_o;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= IDLE;
      timer       <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_cyc_o <= 1'b1;
            timer     <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          if (timer != T_MAX) timer <= timer + 1'b1;
          // Ack takes priority over a timeout landing on the same edge.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (TIMEOUT != 0 && timer == T_LAST) begin
            wbm_cyc_o   <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator: directed vector table, corner sequences and a
// randomized stream against a register-file slave and a transaction-level model.
module tb_wb_cmd_initiator;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack, busy;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;

  int total = 0, bad = 0;

  wb_cmd_initiator #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdat), .wbm_ack_i(ack),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Slave: 4 word registers, ack after ack_lat cycles of cyc (0 = first cycle).
  logic [31:0] mem [4];
  int          bus_cnt = 0;
  int          ack_lat = 0;
  logic        ack_force = 1'b0;

  assign ack  = ack_force | (cyc && bus_cnt == ack_lat);
  assign rdat = mem[adr[3:2]];

  always @(posedge clk) begin
    bus_cnt <= cyc ? bus_cnt + 1 : 0;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (cyc && ack && we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) mem[adr[3:2]][b*8 +: 8] <= wdat[b*8 +: 8];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Protocol invariants sampled every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (stb !== cyc || (cyc && cmd_ready) || busy === cmd_ready) begin
        bad++;
        $display("FAIL invariant cyc=%b stb=%b cmd_ready=%b busy=%b", cyc, stb, cmd_ready, busy);
      end
    end
  end

  // Issues one command and waits for the response, leaving it pending.
  task automatic do_txn(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input int lat,
                        output logic [31:0] rd, output logic er, output int ncyc,
                        output logic hold_ok, output logic ok);
    int n;
    ok = 1'b1; hold_ok = 1'b1; ncyc = 0; rd = '0; er = 1'b0;
    ack_lat = lat;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin ok = 1'b0; return; end
    cmd_valid = 1'b1; cmd_we = w; cmd_sel = s; cmd_adr = a; cmd_dat = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      if (cyc) begin
        ncyc++;
        if ({we, sel, adr, wdat} !== {w, s, a, d}) hold_ok = 1'b0;
      end
      @(negedge clk); n++;
    end
    if (!rsp_valid) begin ok = 1'b0; return; end
    rd = rsp_dat; er = rsp_err;
  endtask

  task automatic consume(input int wait_cyc);
    repeat (wait_cyc) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    int          lat;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] model [4];
  logic [31:0] rd, d0, exp_rd;
  logic        er, hold_ok, ok, w, e0, exp_er;
  logic [3:0]  s;
  int          ncyc, lat, idx;

  initial begin
    tbl[0] = '{1'b1, 4'hF, 32'h3000_0000, 32'h0000_1234, 2, 32'h0,          1'b0, 3};
    tbl[1] = '{1'b1, 4'hF, 32'h3000_0004, 32'hCAFE_F00D, 1, 32'h0,          1'b0, 2};
    tbl[2] = '{1'b0, 4'hF, 32'h3000_0004, 32'h0,         0, 32'hCAFE_F00D, 1'b0, 1};
    tbl[3] = '{1'b1, 4'h3, 32'h3000_0004, 32'hFFFF_1111, 0, 32'h0,          1'b0, 1};
    tbl[4] = '{1'b0, 4'hF, 32'h3000_0004, 32'h0,         2, 32'hCAFE_1111, 1'b0, 3};
    tbl[5] = '{1'b1, 4'hF, 32'h3000_0000, 32'hDEAD_BEEF, 9, 32'h0,          1'b1, TMO};
    tbl[6] = '{1'b0, 4'h2, 32'h3000_0000, 32'h0,         1, 32'h0000_1234, 1'b0, 2};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {58'h0, cmd_ready, cyc, stb, rsp_valid, busy, rsp_err},
        {58'h0, 6'b100000});
    chk("reset_rsp_dat", {32'h0, rsp_dat}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat, tbl[i].lat, rd, er, ncyc, hold_ok, ok);
      chk($sformatf("vec%0d_done", i), {63'h0, ok}, 64'h1);
      chk($sformatf("vec%0d_dat", i), {32'h0, rd}, {32'h0, tbl[i].exp_dat});
      chk($sformatf("vec%0d_err", i), {63'h0, er}, {63'h0, tbl[i].exp_err});
      chk($sformatf("vec%0d_cyc_len", i), 64'(ncyc), 64'(tbl[i].exp_cyc));
      chk($sformatf("vec%0d_wbm_hold", i), {63'h0, hold_ok}, 64'h1);
      consume(0);
    end

    // Timeout then late ack in RESP and IDLE: response and bus must not react.
    do_txn(1'b0, 4'hF, 32'h3000_0004, 32'h0, 100, rd, er, ncyc, hold_ok, ok);
    chk("late_ack_err", {63'h0, er}, 64'h1);
    ack_force = 1'b1;
    repeat (2) @(negedge clk);
    chk("late_ack_resp_held", {31'h0, rsp_valid, rsp_err, rsp_dat}, {31'h0, 2'b11, 32'h0});
    consume(0);
    chk("late_ack_idle", {61'h0, cyc, rsp_valid, cmd_ready}, 64'h1);
    ack_force = 1'b0;

    // Backpressure: response and cmd_ready frozen while rsp_ready is low.
    do_txn(1'b0, 4'hF, 32'h3000_0004, 32'h0, 0, rd, er, ncyc, hold_ok, ok);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k), {29'h0, rsp_valid, rsp_err, cmd_ready, rsp_dat},
          {29'h0, 3'b100, 32'hCAFE_1111});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release", {62'h0, rsp_valid, cmd_ready}, 64'h1);

    // Randomized stream against a transaction-level model of the slave.
    model[0] = 32'h0000_1234; model[1] = 32'hCAFE_1111; model[2] = '0; model[3] = '0;
    for (int t = 0; t < 24; t++) begin
      w   = 1'($urandom_range(0, 1));
      s   = 4'($urandom_range(1, 15));
      idx = $urandom_range(0, 3);
      d0  = $urandom;
      lat = $urandom_range(0, 5);
      exp_er = (lat >= TMO);
      exp_rd = (w || exp_er) ? 32'h0 : model[idx];
      if (w && !exp_er)
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d0[b*8 +: 8];
      do_txn(w, s, 32'h3000_0000 | 32'(idx << 2), d0, lat, rd, er, ncyc, hold_ok, ok);
      chk($sformatf("rnd%0d_done", t), {63'h0, ok}, 64'h1);
      chk($sformatf("rnd%0d_rsp", t), {31'h0, er, rd}, {31'h0, exp_er, exp_rd});
      chk($sformatf("rnd%0d_cyc_len", t), 64'(ncyc), 64'(exp_er ? TMO : lat + 1));
      chk($sformatf("rnd%0d_wbm_hold", t), {63'h0, hold_ok}, 64'h1);
      consume($urandom_range(0, 3));
    end

    // Reset asserted mid-BUS: outputs drop without any clock edge.
    ack_lat = 100;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0000;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_cyc", {63'h0, cyc}, 64'h1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {60'h0, cyc, stb, rsp_valid, cmd_ready}, 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {62'h0, cmd_ready, busy}, 64'h2);
    e0 = 1'b0;
    repeat (6) begin @(negedge clk); e0 = e0 | rsp_valid | cyc; end
    chk("rst_no_spurious", {63'h0, e0}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
